// File: rtl/dispense_sequencer.sv
// Vending actuator sequencer: queues item/change jobs (up to two per clock) and plays them out
// one at a time as fixed-length pulses separated by idle gaps. Jobs that do not fit are dropped and flagged.
module dispense_sequencer #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] out_code,
  input  logic [1:0] change_code,
  output logic       motor_std,
  output logic       motor_special,
  output logic       coin5_sol,
  output logic       coin10_sol,
  output logic       reject_sol,
  output logic       busy,
  output logic       job_done,
  output logic       overflow,
  output logic       code_err,
  output logic [7:0] vend_count
);

  localparam logic [2:0] JOB_STD     = 3'd0;
  localparam logic [2:0] JOB_SPECIAL = 3'd1;
  localparam logic [2:0] JOB_C5      = 3'd2;
  localparam logic [2:0] JOB_C10     = 3'd3;
  localparam logic [2:0] JOB_REJECT  = 3'd4;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [2:0] job_q, job_d;
  logic [4:0] act_q, act_d;
  logic       job_done_q, job_done_d;
  logic       overflow_q, overflow_d;
  logic       code_err_q, code_err_d;
  logic [7:0] vend_q, vend_d;
  logic [2:0] mem_q [8];
  logic [2:0] mem_d [8];
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;

  logic       item_vld, chg_vld, item_push, chg_push, pop;
  logic [2:0] item_job, chg_job, head;
  logic [3:0] free;

  always_comb begin
    item_vld = (out_code == 2'b01) || (out_code == 2'b10);
    item_job = (out_code == 2'b01) ? JOB_STD : JOB_SPECIAL;
    chg_vld  = (change_code != 2'b00);
    case (change_code)
      2'b01:   chg_job = JOB_C5;
      2'b10:   chg_job = JOB_C10;
      default: chg_job = JOB_REJECT;
    endcase
    head = mem_q[rd_ptr_q];

    // The last gap clock pops directly so the idle time between pulses is exactly GAP_CYCLES.
    pop  = (count_q != 4'd0) &&
           ((state_q == IDLE) || ((state_q == GAP) && (timer_q == 4'd0)));
    free = 4'd8 - count_q + 4'(pop);

    // Item job has priority for the free slots; a same-clock pop frees one.
    item_push = item_vld && (free >= 4'd1);
    chg_push  = chg_vld && (free >= (item_push ? 4'd2 : 4'd1));

    mem_d = mem_q;
    if (item_push) mem_d[wr_ptr_q] = item_job;
    if (chg_push)  mem_d[wr_ptr_q + 3'(item_push)] = chg_job;
    wr_ptr_d = wr_ptr_q + 3'(item_push) + 3'(chg_push);
    rd_ptr_d = rd_ptr_q + 3'(pop);
    count_d  = count_q + 4'(item_push) + 4'(chg_push) - 4'(pop);

    overflow_d = overflow_q | (item_vld & ~item_push) | (chg_vld & ~chg_push);
    code_err_d = code_err_q | (out_code == 2'b11);

    state_d    = state_q;
    timer_d    = timer_q;
    job_d      = job_q;
    act_d      = act_q;
    job_done_d = 1'b0;
    vend_d     = vend_q;

    if (pop) begin
      state_d = PULSE;
      timer_d = PULSE_LAST;
      job_d   = head;
      act_d   = 5'b00001 << head;
    end else begin
      case (state_q)
        PULSE: begin
          if (timer_q == 4'd0) begin
            state_d    = GAP;
            timer_d    = GAP_LAST;
            act_d      = 5'b00000;
            job_done_d = 1'b1;
            if (((job_q == JOB_STD) || (job_q == JOB_SPECIAL)) && (vend_q != 8'hFF))
              vend_d = vend_q + 8'd1;
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end
        GAP: begin
          if (timer_q == 4'd0) state_d = IDLE;
          else timer_d = timer_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= 4'd0;
      job_q      <= JOB_STD;
      act_q      <= 5'b00000;
      job_done_q <= 1'b0;
      overflow_q <= 1'b0;
      code_err_q <= 1'b0;
      vend_q     <= 8'd0;
      mem_q      <= '{default: 3'd0};
      wr_ptr_q   <= 3'd0;
      rd_ptr_q   <= 3'd0;
      count_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      job_q      <= job_d;
      act_q      <= act_d;
      job_done_q <= job_done_d;
      overflow_q <= overflow_d;
      code_err_q <= code_err_d;
      vend_q     <= vend_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign motor_std     = act_q[0];
  assign motor_special = act_q[1];
  assign coin5_sol     = act_q[2];
  assign coin10_sol    = act_q[3];
  assign reject_sol    = act_q[4];
  assign job_done      = job_done_q;
  assign overflow      = overflow_q;
  assign code_err      = code_err_q;
  assign vend_count    = vend_q;
  assign busy          = (count_q != 4'd0) || (state_q != IDLE);

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer: stimulus pushes expected pulses into a scoreboard,
// a negedge monitor measures each actuator pulse (type, length, preceding gap) and compares.
module tb_dispense_sequencer;

  localparam int PULSE = 4;
  localparam logic [4:0] A_STD = 5'b00001;
  localparam logic [4:0] A_SPC = 5'b00010;
  localparam logic [4:0] A_C5  = 5'b00100;
  localparam logic [4:0] A_C10 = 5'b01000;
  localparam logic [4:0] A_REJ = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] out_code = 2'b00;
  logic [1:0] change_code = 2'b00;
  logic       motor_std, motor_special, coin5_sol, coin10_sol, reject_sol;
  logic       busy, job_done, overflow, code_err;
  logic [7:0] vend_count;

  dispense_sequencer #(.PULSE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .out_code     (out_code),
    .change_code  (change_code),
    .motor_std    (motor_std),
    .motor_special(motor_special),
    .coin5_sol    (coin5_sol),
    .coin10_sol   (coin10_sol),
    .reject_sol   (reject_sol),
    .busy         (busy),
    .job_done     (job_done),
    .overflow     (overflow),
    .code_err     (code_err),
    .vend_count   (vend_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] act;
    int         len;
    int         gap;  // 0 means the preceding idle time is not checked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic expect_job(input logic [4:0] a, input int gap);
    exp_t e;
    e.act = a;
    e.len = PULSE;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic ev(input logic [1:0] o, input logic [1:0] c);
    @(negedge clk);
    out_code    = o;
    change_code = c;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      out_code    = 2'b00;
      change_code = 2'b00;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("busy_clears_in_budget", int'(busy), 0);
  endtask

  function automatic int act_vec();
    return int'({reject_sol, coin10_sol, coin5_sol, motor_special, motor_std});
  endfunction

  // Monitor: one scoreboard pop per completed actuator pulse.
  logic [4:0] mon_act, mon_prev;
  int         mon_len, mon_low, mon_gap;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      mon_prev = 5'b0;
      mon_len  = 0;
      mon_low  = 100;
    end else begin
      mon_act = {reject_sol, coin10_sol, coin5_sol, motor_special, motor_std};
      if ($countones(mon_act) > 1) chk("one_hot_actuators", $countones(mon_act), 1);
      if (mon_act != 5'b0 && mon_prev == 5'b0) begin
        mon_len = 1;
        mon_gap = mon_low;
      end else if (mon_act != 5'b0) begin
        if (mon_act != mon_prev) chk("actuator_stable", int'(mon_act), int'(mon_prev));
        mon_len++;
      end else if (mon_prev != 5'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'(mon_prev), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_actuator", int'(mon_prev), int'(mon_e.act));
          chk("pulse_length", mon_len, mon_e.len);
          if (mon_e.gap > 0) chk("gap_length", mon_gap, mon_e.gap);
        end
        chk("job_done_at_pulse_end", int'(job_done), 1);
        mon_low = 1;
      end else begin
        mon_low++;
      end
      if (job_done && !(mon_act == 5'b0 && mon_prev != 5'b0))
        chk("job_done_stray", int'(job_done), 0);
      mon_prev = mon_act;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state; events presented during reset must be ignored.
    ev(2'b01, 2'b11);
    idle_n(0);
    @(negedge clk);
    chk("rst_actuators", act_vec(), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_job_done", int'(job_done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_code_err", int'(code_err), 0);
    chk("rst_vend_count", int'(vend_count), 0);
    out_code    = 2'b00;
    change_code = 2'b00;
    rst         = 1'b1;
    idle_n(2);
    chk("no_event_after_reset", int'(busy), 0);

    // Single vend: one-clock latency, 4-clock pulse, count increments.
    expect_job(A_STD, 0);
    ev(2'b01, 2'b00);
    idle_n(1);
    chk("single_enqueued_not_yet_firing", int'(motor_std), 0);
    chk("single_busy", int'(busy), 1);
    @(negedge clk);
    chk("single_fires_next_edge", int'(motor_std), 1);
    wait_idle(50);
    chk("single_vend_count", int'(vend_count), 1);

    // Simultaneous item + change: item first, 2-clock gap, then coin5.
    expect_job(A_STD, 0);
    expect_job(A_C5, 2);
    ev(2'b01, 2'b01);
    idle_n(1);
    wait_idle(50);
    chk("simul_vend_count", int'(vend_count), 2);

    // Overflow: five clocks of special + coin10 while the first pulse runs.
    expect_job(A_SPC, 0);
    for (int i = 0; i < 4; i++) begin
      expect_job(A_C10, 2);
      expect_job(A_SPC, 2);
    end
    for (int i = 0; i < 5; i++) begin
      ev(2'b10, 2'b10);
      if (i == 4) chk("no_overflow_before_full", int'(overflow), 0);
    end
    idle_n(1);
    chk("overflow_set", int'(overflow), 1);
    wait_idle(200);
    chk("overflow_sticky", int'(overflow), 1);
    chk("overflow_vend_count", int'(vend_count), 7);

    // Invalid item code fires nothing; reject code drives reject_sol.
    ev(2'b11, 2'b00);
    idle_n(1);
    chk("code_err_set", int'(code_err), 1);
    chk("code11_not_queued", int'(busy), 0);
    expect_job(A_REJ, 0);
    ev(2'b00, 2'b11);
    idle_n(1);
    wait_idle(50);
    chk("reject_vend_unchanged", int'(vend_count), 7);

    // Reset at the 2nd clock of a pulse with 3 jobs queued.
    ev(2'b01, 2'b01);
    ev(2'b10, 2'b00);
    ev(2'b00, 2'b10);
    @(negedge clk);
    out_code    = 2'b00;
    change_code = 2'b00;
    chk("midreset_pulse_running", int'(motor_std), 1);
    #2 rst = 1'b0;
    #1;
    chk("midreset_actuators", act_vec(), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_code_err", int'(code_err), 0);
    chk("midreset_overflow", int'(overflow), 0);
    idle_n(2);
    rst = 1'b1;
    idle_n(20);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_vend", int'(vend_count), 0);

    // Saturation: 260 standard jobs, paced so the queue never fills.
    for (int j = 0; j < 260; j++) begin
      expect_job(A_STD, 0);
      ev(2'b01, 2'b00);
      idle_n(7);
      if (j == 253) begin
        wait_idle(50);
        chk("vend_count_254", int'(vend_count), 254);
      end
    end
    wait_idle(50);
    chk("vend_count_saturated", int'(vend_count), 255);
    chk("sat_no_overflow", int'(overflow), 0);
    idle_n(2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
